pipeline_run_controller: RTL and testbench
==========================================

# pipeline_run_controller

Sequencer for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). Drives the per-stage enables in continuous-run or single-step mode. Detects the HALT instruction presented to ID, stops fetch, drains the remaining stages, and reports completion together with an executed-cycle count. It sits beside the pipeline and feeds each stage's `enable` input (e.g. `i_ID_enable`).

## Interface
- `NB_INST`, 32, instruction width
- `NB_OPCODE`, 6, opcode field width (`inst[31:26]`)
- `NB_STAGES`, 5, number of stage enables (bit0 IF … bit4 WB)
- `NB_CYCLES`, 32, cycle counter width
- `DRAIN_CYCLES`, 4, enabled cycles needed to retire HALT's predecessors after fetch stops
- `HALT_OPCODE`, 6'b111111, opcode treated as HALT
---
- `i_CTL_clock`  in  1  clock; all state changes on the rising edge
- `i_CTL_reset`  in  1  reset; asynchronous, active-high
- `i_CTL_start`  in  1  start request; sampled on the clock edge
- `i_CTL_step_mode`  in  1  0 = continuous, 1 = single-step; latched on an accepted start
- `i_CTL_step`  in  1  advance one cycle (step mode only)
- `i_CTL_stop`  in  1  abort the run
- `i_CTL_inst`  in  NB_INST  instruction currently at the ID input (IF/ID latch output)
- `o_CTL_enable`  out  NB_STAGES  registered per-stage enable
- `o_CTL_busy`  out  1  high in RUN or DRAIN
- `o_CTL_draining`  out  1  high in DRAIN
- `o_CTL_done`  out  1  high in DONE
- `o_CTL_cycles`  out  NB_CYCLES  count of cycles with any enable bit high

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. A mode flag is latched from `i_CTL_step_mode` on an accepted start.
- **Reset:** state IDLE. All outputs are 0, the drain counter is 0 and the mode flag is 0.
- **Start:**
  - Accepted only in IDLE or DONE.
  - On acceptance: state RUN, `o_CTL_cycles` cleared to 0, mode latched.
  - Ignored in RUN and DRAIN.
- **The advance condition for a cycle** is:
  - mode = continuous: always, or
  - mode = step and `i_CTL_step` is sampled high.
- **RUN:**
  - Next `o_CTL_enable` = 5'b11111 if advance, else 5'b00000.
  - `i_CTL_step` is ignored in continuous mode.
- **HALT detection:**
  - Condition: in RUN, in a cycle where `o_CTL_enable[0]` = 1 and `i_CTL_inst[31:26]` = HALT_OPCODE.
  - At that edge: state DRAIN, drain counter loaded with DRAIN_CYCLES.
  - The enable output computed at that same edge already uses the DRAIN rule. Fetch therefore stops immediately after the HALT cycle.
- **DRAIN:**
  - Next `o_CTL_enable` = 5'b11110 if advance, else 0. IF is frozen, so the PC holds. ID re-decodes HALT, which produces no writes.
  - The drain counter decrements on each edge whose output enable is nonzero.
  - When the counter reaches 0: state DONE, enables 0.
- **DONE:** enables 0, `o_CTL_done` = 1. Held until start or reset.
- **Stop:**
  - In RUN or DRAIN: next state IDLE, enables 0.
  - `o_CTL_cycles` holds its value; `o_CTL_done` stays 0.
  - Ignored in IDLE and DONE.
- **Priority (highest first):** reset, stop, HALT detection, start/step.
- **Cycle counter:**
  - Increments by 1 on each edge where the current `o_CTL_enable` ≠ 0.
  - Saturates at all-ones; no wrap.
- HALT presented while enable[0] = 0 (stalled step mode) is not detected until a cycle in which it is enabled.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Continuous mode:**
  - start sampled at edge k → enable = 11111 from cycle k+1.
  - HALT enabled in cycle h → enable = 11110 in cycles h+1 … h+DRAIN_CYCLES.
  - `o_CTL_done` = 1 from cycle h+DRAIN_CYCLES+1.
- **Step mode:**
  - start leaves enable = 0.
  - step sampled at edge s → enable nonzero for exactly cycle s+1.
  - Back-to-back steps produce consecutive enabled cycles.
  - In DRAIN, each step advances the drain count by one.
- **Stop sampled at edge k:** enable = 0 and busy = 0 from cycle k+1.
- **Asynchronous reset mid-run or mid-drain:** all outputs go to 0 immediately, with no clock edge required. Release is synchronous to the next edge.
- **Status flags:** `o_CTL_busy` and `o_CTL_draining` follow the registered state in the same cycle as the enable they accompany.

## Test plan
- **Reset:** assert `i_CTL_reset` with no clock → enable = 0, busy = 0, done = 0, cycles = 0; toggling step/stop in IDLE changes nothing.
- **Continuous run:** start (step_mode = 0); ID sees non-HALT for 10 enabled cycles, then `0xFC000000` → 11 cycles of 11111, 4 cycles of 11110, then done = 1, enable = 0, cycles = 15.
- **Single-step:** start (step_mode = 1); step pulses at cycles 5, 9, 10 → enable = 11111 only in cycles 6, 10 and 11; cycles = 3; busy = 1 throughout.
- **Step into HALT:** step mode with HALT at ID, one step → next four steps each give exactly one 11110 cycle; done rises after the fourth.
- **Stop mid-run:** stop after 7 enabled cycles → enable = 0 next cycle, busy = 0, done = 0, cycles = 7; a repeated start clears cycles to 0.
- **Edge cases:**
  - Start during RUN → ignored.
  - Stop and HALT detection in the same cycle → stop wins, IDLE.
  - Asynchronous reset during DRAIN → immediate zeros.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// Run/step sequencer for the five-stage pipeline: drives per-stage enables, stops fetch on HALT and drains.
// All outputs are registered (one-edge latency from any input); stop overrides HALT detection, which overrides start/step.
module pipeline_run_controller #(
    parameter int                   NB_INST      = 32,
    parameter int                   NB_OPCODE    = 6,
    parameter int                   NB_STAGES    = 5,
    parameter int                   NB_CYCLES    = 32,
    parameter int                   DRAIN_CYCLES = 4,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = 6'b111111
) (
    input  logic                 i_CTL_clock,
    input  logic                 i_CTL_reset,
    input  logic                 i_CTL_start,
    input  logic                 i_CTL_step_mode,
    input  logic                 i_CTL_step,
    input  logic                 i_CTL_stop,
    input  logic [NB_INST-1:0]   i_CTL_inst,
    output logic [NB_STAGES-1:0] o_CTL_enable,
    output logic                 o_CTL_busy,
    output logic                 o_CTL_draining,
    output logic                 o_CTL_done,
    output logic [NB_CYCLES-1:0] o_CTL_cycles
);

    localparam int NB_DRAIN = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [NB_STAGES-1:0] EN_ALL   = {NB_STAGES{1'b1}};
    // IF is held off while draining so the PC stays parked on HALT.
    localparam logic [NB_STAGES-1:0] EN_DRAIN = {{(NB_STAGES-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic                mode;
    logic [NB_DRAIN-1:0] drain_cnt;

    logic advance;
    logic halt_hit;
    logic any_enable;
    logic unused_inst;

    assign advance    = ~mode | i_CTL_step;
    assign any_enable = |o_CTL_enable;
    assign halt_hit   = o_CTL_enable[0] &&
                        (i_CTL_inst[NB_INST-1 -: NB_OPCODE] == HALT_OPCODE);

    // Only the opcode field is decoded.
    assign unused_inst = ^i_CTL_inst[NB_INST-NB_OPCODE-1:0];

    always_ff @(posedge i_CTL_clock or posedge i_CTL_reset) begin
        if (i_CTL_reset) begin
            state          <= IDLE;
            mode           <= 1'b0;
            drain_cnt      <= '0;
            o_CTL_enable   <= '0;
            o_CTL_busy     <= 1'b0;
            o_CTL_draining <= 1'b0;
            o_CTL_done     <= 1'b0;
            o_CTL_cycles   <= '0;
        end else begin
            if (any_enable && !(&o_CTL_cycles))
                o_CTL_cycles <= o_CTL_cycles + NB_CYCLES'(1);

            case (state)
                IDLE, DONE: begin
                    if (i_CTL_start) begin
                        state          <= RUN;
                        mode           <= i_CTL_step_mode;
                        o_CTL_cycles   <= '0;
                        o_CTL_enable   <= i_CTL_step_mode ? '0 : EN_ALL;
                        o_CTL_busy     <= 1'b1;
                        o_CTL_draining <= 1'b0;
                        o_CTL_done     <= 1'b0;
                    end
                end

                RUN: begin
                    if (i_CTL_stop) begin
                        state          <= IDLE;
                        o_CTL_enable   <= '0;
                        o_CTL_busy     <= 1'b0;
                        o_CTL_draining <= 1'b0;
                    end else if (halt_hit) begin
                        if (DRAIN_CYCLES == 0) begin
                            state        <= DONE;
                            o_CTL_enable <= '0;
                            o_CTL_busy   <= 1'b0;
                            o_CTL_done   <= 1'b1;
                        end else begin
                            state          <= DRAIN;
                            drain_cnt      <= NB_DRAIN'(DRAIN_CYCLES);
                            o_CTL_enable   <= advance ? EN_DRAIN : '0;
                            o_CTL_draining <= 1'b1;
                        end
                    end else begin
                        o_CTL_enable <= advance ? EN_ALL : '0;
                    end
                end

                DRAIN: begin
                    if (i_CTL_stop) begin
                        state          <= IDLE;
                        o_CTL_enable   <= '0;
                        o_CTL_busy     <= 1'b0;
                        o_CTL_draining <= 1'b0;
                    end else if (any_enable && drain_cnt == NB_DRAIN'(1)) begin
                        state          <= DONE;
                        drain_cnt      <= '0;
                        o_CTL_enable   <= '0;
                        o_CTL_busy     <= 1'b0;
                        o_CTL_draining <= 1'b0;
                        o_CTL_done     <= 1'b1;
                    end else begin
                        // Stalled step-mode cycles do not consume drain credit.
                        if (any_enable)
                            drain_cnt <= drain_cnt - NB_DRAIN'(1);
                        o_CTL_enable <= advance ? EN_DRAIN : '0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    o_CTL_enable <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller with hand-derived expected values.
module tb_pipeline_run_controller;

    localparam logic [4:0]  EN_ALL = 5'b11111;
    localparam logic [4:0]  EN_DRN = 5'b11110;
    localparam logic [31:0] HALT   = 32'hFC000000;
    localparam logic [31:0] NOP    = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] inst = NOP;
    logic [4:0]  enable;
    logic        busy;
    logic        draining;
    logic        done;
    logic [31:0] cycles;

    int errors = 0;
    int checks = 0;

    pipeline_run_controller dut (
        .i_CTL_clock     (clk),
        .i_CTL_reset     (rst),
        .i_CTL_start     (start),
        .i_CTL_step_mode (step_mode),
        .i_CTL_step      (step),
        .i_CTL_stop      (stop),
        .i_CTL_inst      (inst),
        .o_CTL_enable    (enable),
        .o_CTL_busy      (busy),
        .o_CTL_draining  (draining),
        .o_CTL_done      (done),
        .o_CTL_cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] en, input logic bsy,
                           input logic drn, input logic dn);
        chk({tag, ".enable"},   32'(enable),   32'(en));
        chk({tag, ".busy"},     32'(busy),     32'(bsy));
        chk({tag, ".draining"}, 32'(draining), 32'(drn));
        chk({tag, ".done"},     32'(done),     32'(dn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with no clock edge yet.
        #1;
        chk_out("reset", 5'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.cycles", cycles, 32'd0);
        #2 rst = 1'b0;

        // Step/stop in IDLE have no effect.
        step = 1'b1; stop = 1'b1;
        repeat (3) tick();
        chk_out("idle_toggle", 5'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_toggle.cycles", cycles, 32'd0);
        step = 1'b0; stop = 1'b0;

        // Continuous run: 10 non-HALT cycles, then HALT.
        start = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_out($sformatf("cont_run%0d", i), EN_ALL, 1'b1, 1'b0, 1'b0);
            if (i == 6) chk("start_in_run.cycles", cycles, 32'd6);
            start = (i == 5);
            tick();
            start = 1'b0;
        end
        inst = HALT;
        chk_out("cont_halt", EN_ALL, 1'b1, 1'b0, 1'b0);
        chk("cont_halt.cycles", cycles, 32'd10);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("cont_drain%0d", i), EN_DRN, 1'b1, 1'b1, 1'b0);
            tick();
        end
        chk_out("cont_done", 5'b0, 1'b0, 1'b0, 1'b1);
        chk("cont_done.cycles", cycles, 32'd15);
        tick();
        chk_out("done_hold", 5'b0, 1'b0, 1'b0, 1'b1);

        // Single-step: pulses before edges 5, 9 and 10.
        inst = NOP;
        start = 1'b1; step_mode = 1'b1;
        tick();
        start = 1'b0; step_mode = 1'b0;
        chk_out("step_start", 5'b0, 1'b1, 1'b0, 1'b0);
        chk("step_start.cycles", cycles, 32'd0);
        for (int t = 1; t <= 12; t++) begin
            step = (t == 5 || t == 9 || t == 10);
            tick();
            step = 1'b0;
            chk_out($sformatf("step_t%0d", t),
                    (t == 5 || t == 9 || t == 10) ? EN_ALL : 5'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("step.cycles", cycles, 32'd3);

        // Step into HALT, then four drain steps.
        inst = HALT;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_out("step_halt_en", EN_ALL, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("step_halt_det", 5'b0, 1'b1, 1'b1, 1'b0);
        chk("step_halt_det.cycles", cycles, 32'd4);
        for (int j = 0; j < 4; j++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk_out($sformatf("step_drain%0d", j), EN_DRN, 1'b1, 1'b1, 1'b0);
            tick();
            if (j < 3) chk_out($sformatf("step_wait%0d", j), 5'b0, 1'b1, 1'b1, 1'b0);
            else       chk_out("step_done", 5'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("step_done.cycles", cycles, 32'd8);

        // Stop after 7 enabled cycles, then restart.
        inst = NOP;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk_out("pre_stop", EN_ALL, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("stop", 5'b0, 1'b0, 1'b0, 1'b0);
        chk("stop.cycles", cycles, 32'd7);
        tick();
        chk("stop_hold.cycles", cycles, 32'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("restart", EN_ALL, 1'b1, 1'b0, 1'b0);
        chk("restart.cycles", cycles, 32'd0);

        // Stop and HALT in the same cycle: stop wins.
        inst = HALT; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("stop_vs_halt", 5'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_vs_halt.cycles", cycles, 32'd1);

        // Asynchronous reset in DRAIN.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_out("pre_areset", EN_DRN, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("areset", 5'b0, 1'b0, 1'b0, 1'b0);
        chk("areset.cycles", cycles, 32'd0);
        #1 rst = 1'b0;
        inst = NOP;
        tick();
        chk_out("post_areset", 5'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
